// File: rtl/cpu_csr_access.sv
// Zicsr read-modify-write sequencer between execute and the CSR register file.
// Optional `CPU_CSR_RO_CHECK_EN flags writes to read-only CSRs (addr[11:10]==2'b11) as illegal.
module cpu_csr_access (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [31:0] req_src_i,
  input  logic [4:0]  req_zimm_i,
  input  logic        req_rs1_zero_i,
  input  logic        req_rd_zero_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_illegal_o,
  output logic [11:0] csr_read_addr_o,
  output logic        csr_read_enable_o,
  input  logic [31:0] csr_read_data_i,
  output logic [11:0] csr_write_addr_o,
  output logic [31:0] csr_write_data_o,
  output logic        csr_write_enable_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MODIFY,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  r_op;
  logic [11:0] r_addr;
  logic [31:0] r_operand;
  logic        r_needWrite;
  logic        r_illegal;
  logic [31:0] r_old;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic        w_isRw;
  logic        w_opIllegal;
  logic        w_needRead;
  logic        w_needWrite;
  logic        w_roBlock;
  logic [31:0] w_operand;

  // op[1:0]: 01 write, 10 set bits, 11 clear bits; no carries anywhere
  function automatic logic [31:0] newValue(input logic [1:0] op,
                                           input logic [31:0] old,
                                           input logic [31:0] operand);
    case (op)
      2'b01:   newValue = operand;
      2'b10:   newValue = old | operand;
      default: newValue = old & ~operand;
    endcase
  endfunction

  assign w_accept    = req_valid_i && (r_state == S_IDLE);
  assign w_isRw      = (req_op_i[1:0] == 2'b01);
  assign w_opIllegal = (req_op_i[1:0] == 2'b00);
  assign w_operand   = req_op_i[2] ? {27'b0, req_zimm_i} : req_src_i;
  assign w_needRead  = !(w_isRw && req_rd_zero_i);
  assign w_needWrite = w_isRw || !req_rs1_zero_i;

`ifdef CPU_CSR_RO_CHECK_EN
  assign w_roBlock = (req_addr_i[11:10] == 2'b11) && w_needWrite;
`else
  assign w_roBlock = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A read-only violation still performs the read so rd gets the old value
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_opIllegal)     w_nextState = S_RESP;
          else if (w_needRead) w_nextState = S_READ;
          else if (w_roBlock)  w_nextState = S_RESP;
          else                 w_nextState = S_WRITE;
        end
      end
      S_READ:   w_nextState = S_MODIFY;
      S_MODIFY: w_nextState = (r_needWrite && !r_illegal) ? S_WRITE : S_RESP;
      S_WRITE:  w_nextState = S_RESP;
      S_RESP:   if (rsp_ready_i) w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_op        <= 2'b00;
      r_addr      <= 12'h000;
      r_operand   <= 32'h0;
      r_needWrite <= 1'b0;
      r_illegal   <= 1'b0;
      r_old       <= 32'h0;
      r_wdata     <= 32'h0;
    end else if (w_accept) begin
      r_op        <= req_op_i[1:0];
      r_addr      <= req_addr_i;
      r_operand   <= w_operand;
      r_needWrite <= w_needWrite;
      r_illegal   <= w_opIllegal || w_roBlock;
      r_old       <= 32'h0;
      r_wdata     <= newValue(req_op_i[1:0], 32'h0, w_operand);
    end else if (r_state == S_MODIFY) begin
      r_old       <= csr_read_data_i;
      r_wdata     <= newValue(r_op, csr_read_data_i, r_operand);
    end
  end

  assign req_ready_o        = (r_state == S_IDLE);
  assign csr_read_enable_o  = (r_state == S_READ);
  assign csr_write_enable_o = (r_state == S_WRITE);
  assign rsp_valid_o        = (r_state == S_RESP);
  assign rsp_data_o         = (r_state == S_RESP) ? r_old : 32'h0;
  assign rsp_illegal_o      = (r_state == S_RESP) && r_illegal;
  assign csr_read_addr_o    = r_addr;
  assign csr_write_addr_o   = r_addr;
  assign csr_write_data_o   = r_wdata;

endmodule
